// File: rtl/test_multi_port_mem.sv
// Response queue: small circular buffer holding responses awaiting sink acceptance.
// Latency: dout valid the cycle after push. Backpressure: caller guarantees no overflow.
module mem_resp_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [p_width-1:0] din,
    output logic [p_width-1:0] dout,
    output logic               empty
);
    localparam int AW = $clog2(p_depth);

    logic [p_width-1:0] buf_q [p_depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr] <= din;
    end

    assign dout  = buf_q[rd_ptr];
    assign empty = (count == '0);
endmodule

// Multi-port byte-addressed test memory; every port accesses memory in its acceptance cycle.
// Latency: response valid exactly p_resp_latency cycles after acceptance when the sink keeps up.
// Backpressure: per-port credits; rdy drops once p_resp_depth responses are outstanding.
module test_multi_port_mem #(
    parameter int p_num_ports    = 2,
    parameter int p_mem_sz       = 1024,
    parameter int p_addr_sz      = 16,
    parameter int p_data_sz      = 32,
    parameter int p_resp_latency = 1,
    parameter int p_resp_depth   = 4
) (
    input  logic                                                            clk,
    input  logic                                                            reset,
    input  logic [p_num_ports-1:0]                                          memreq_val,
    output logic [p_num_ports-1:0]                                          memreq_rdy,
    input  logic [p_num_ports*(1+p_addr_sz+$clog2(p_data_sz/8)+p_data_sz)-1:0] memreq_msg,
    output logic [p_num_ports-1:0]                                          memresp_val,
    input  logic [p_num_ports-1:0]                                          memresp_rdy,
    output logic [p_num_ports*(1+$clog2(p_data_sz/8)+p_data_sz)-1:0]           memresp_msg
);
    localparam int L  = $clog2(p_data_sz/8);
    localparam int NB = p_data_sz/8;
    localparam int MA = $clog2(p_mem_sz);
    localparam int CW = $clog2(p_resp_depth) + 1;

    typedef struct packed {
        logic                 typ;
        logic [p_addr_sz-1:0] addr;
        logic [L-1:0]         len;
        logic [p_data_sz-1:0] data;
    } req_t;

    typedef struct packed {
        logic                 typ;
        logic [L-1:0]         len;
        logic [p_data_sz-1:0] data;
    } resp_t;

    localparam int REQW  = $bits(req_t);
    localparam int RESPW = $bits(resp_t);

    logic [7:0] m [p_mem_sz];

    req_t                   req     [p_num_ports];
    resp_t                  rd_resp [p_num_ports];
    logic [p_num_ports-1:0] req_fire;

    function automatic int byte_cnt(input logic [L-1:0] len);
        return (len == '0) ? NB : int'(len);
    endfunction

    // Byte address wraps modulo the memory size.
    function automatic logic [MA-1:0] byte_addr(input logic [p_addr_sz-1:0] a, input int k);
        return MA'(a) + MA'(k);
    endfunction

    // Reads see memory as it was before this cycle's writes land.
    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            req[i]      = req_t'(memreq_msg[i*REQW +: REQW]);
            req_fire[i] = memreq_val[i] & memreq_rdy[i];
            rd_resp[i]  = '0;
            if (req[i].typ) begin
                rd_resp[i].typ = 1'b1;
            end else begin
                rd_resp[i].len = req[i].len;
                for (int k = 0; k < NB; k++) begin
                    if (k < byte_cnt(req[i].len))
                        rd_resp[i].data[8*k +: 8] = m[byte_addr(req[i].addr, k)];
                end
            end
        end
    end

    // Later ports overwrite earlier ones on shared bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_ports; i++) begin
            if (req_fire[i] && req[i].typ) begin
                for (int k = 0; k < NB; k++) begin
                    if (k < byte_cnt(req[i].len))
                        m[byte_addr(req[i].addr, k)] <= req[i].data[8*k +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < p_num_ports; i++) begin : g_port
        logic          push_vld;
        resp_t         push_dat;
        resp_t         q_dat;
        logic          q_empty;
        logic          resp_fire;
        logic          rdy_q;
        logic [CW-1:0] outstanding;
        logic [CW-1:0] outstanding_nxt;

        if (p_resp_latency == 1) begin : g_direct
            assign push_vld = req_fire[i];
            assign push_dat = rd_resp[i];
        end else begin : g_pipe
            logic  pv [p_resp_latency-1];
            resp_t pd [p_resp_latency-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < p_resp_latency-1; s++) begin
                        pv[s] <= 1'b0;
                        pd[s] <= '0;
                    end
                end else begin
                    pv[0] <= req_fire[i];
                    pd[0] <= rd_resp[i];
                    for (int s = 1; s < p_resp_latency-1; s++) begin
                        pv[s] <= pv[s-1];
                        pd[s] <= pd[s-1];
                    end
                end
            end

            assign push_vld = pv[p_resp_latency-2];
            assign push_dat = pd[p_resp_latency-2];
        end

        // Credits cover the pipeline too, so the queue can never overflow.
        mem_resp_fifo #(
            .p_width (RESPW),
            .p_depth (p_resp_depth)
        ) u_resp_q (
            .clk   (clk),
            .reset (reset),
            .push  (push_vld),
            .pop   (resp_fire),
            .din   (push_dat),
            .dout  (q_dat),
            .empty (q_empty)
        );

        assign memresp_val[i]                   = !q_empty;
        assign memresp_msg[i*RESPW +: RESPW]    = q_dat;
        assign resp_fire                        = !q_empty & memresp_rdy[i];
        assign memreq_rdy[i]                    = rdy_q;

        always_comb begin
            outstanding_nxt = outstanding;
            if (req_fire[i] && !resp_fire)
                outstanding_nxt = outstanding + 1'b1;
            else if (!req_fire[i] && resp_fire)
                outstanding_nxt = outstanding - 1'b1;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                outstanding <= '0;
                rdy_q       <= 1'b0;
            end else begin
                outstanding <= outstanding_nxt;
                rdy_q       <= (outstanding_nxt < CW'(p_resp_depth));
            end
        end
    end
endmodule

// File: tb/tb_test_multi_port_mem.sv
// Bench for test_multi_port_mem: directed scenarios plus random traffic against a byte-array model.
module tb_test_multi_port_mem;
    localparam int NP    = 3;
    localparam int MEM   = 1024;
    localparam int AW    = 16;
    localparam int D     = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int L     = $clog2(D/8);
    localparam int NB    = D/8;
    localparam int REQW  = 1 + AW + L + D;
    localparam int RESPW = 1 + L + D;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NP-1:0]        memreq_val;
    logic [NP-1:0]        memreq_rdy;
    logic [NP*REQW-1:0]   memreq_msg;
    logic [NP-1:0]        memresp_val;
    logic [NP-1:0]        memresp_rdy;
    logic [NP*RESPW-1:0]  memresp_msg;

    always #5 clk = ~clk;

    test_multi_port_mem #(
        .p_num_ports    (NP),
        .p_mem_sz       (MEM),
        .p_addr_sz      (AW),
        .p_data_sz      (D),
        .p_resp_latency (LAT),
        .p_resp_depth   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    typedef struct packed {
        logic [RESPW-1:0] msg;
        int               acc;
    } pend_t;

    logic [7:0]       ref_mem [MEM];
    pend_t            pend    [NP][$];
    logic [RESPW-1:0] obs_msg [NP][$];
    int               obs_lat [NP][$];
    int               fired   [NP];
    int               cyc    = 0;
    int               checks = 0;
    int               errors = 0;
    bit               live   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQW-1:0] mk_req(input bit typ, input int addr, input int len,
                                               input logic [D-1:0] data);
        return {typ, AW'(addr), L'(len), data};
    endfunction

    function automatic logic [RESPW-1:0] mk_resp(input bit typ, input int len, input logic [D-1:0] data);
        return {typ, L'(len), data};
    endfunction

    function automatic int nbytes(input logic [REQW-1:0] r);
        int len;
        len = int'(r[D +: L]);
        return (len == 0) ? NB : len;
    endfunction

    function automatic logic [RESPW-1:0] model_resp(input logic [REQW-1:0] r);
        logic [D-1:0] data;
        int           a;
        if (r[REQW-1]) return mk_resp(1'b1, 0, '0);
        a    = int'(r[REQW-2 -: AW]);
        data = '0;
        for (int k = 0; k < nbytes(r); k++) data[8*k +: 8] = ref_mem[(a + k) % MEM];
        return {1'b0, r[D +: L], data};
    endfunction

    function automatic void model_write(input logic [REQW-1:0] r);
        int a;
        a = int'(r[REQW-2 -: AW]);
        for (int k = 0; k < nbytes(r); k++) ref_mem[(a + k) % MEM] = r[8*k +: 8];
    endfunction

    // One clock: sample at negedge, update the model, return just after posedge.
    task automatic step();
        logic [REQW-1:0] r;
        logic [REQW-1:0] wr_q [$];
        pend_t           p;
        bit              exp_val;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            exp_val = live && pend[i].size() > 0 && (pend[i][0].acc + LAT <= cyc);
            check($sformatf("rdy%0d", i), memreq_rdy[i], live && pend[i].size() < DEPTH);
            check($sformatf("resp_val%0d", i), memresp_val[i], exp_val);
            if (memresp_val[i] && memresp_rdy[i]) begin
                if (pend[i].size() == 0) begin
                    check($sformatf("unexpected_resp%0d", i), memresp_val[i], 1'b0);
                end else begin
                    p = pend[i].pop_front();
                    check($sformatf("resp_msg%0d", i), memresp_msg[i*RESPW +: RESPW], p.msg);
                    obs_msg[i].push_back(memresp_msg[i*RESPW +: RESPW]);
                    obs_lat[i].push_back(cyc - p.acc);
                end
            end
            if (memreq_val[i] && memreq_rdy[i]) begin
                r     = memreq_msg[i*REQW +: REQW];
                p.msg = model_resp(r);
                p.acc = cyc;
                pend[i].push_back(p);
                fired[i]++;
                if (r[REQW-1]) wr_q.push_back(r);
            end
        end
        foreach (wr_q[k]) model_write(wr_q[k]);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int p, input logic [REQW-1:0] r);
        int f0;
        f0 = fired[p];
        memreq_val[p] = 1'b1;
        memreq_msg[p*REQW +: REQW] = r;
        for (int t = 0; t < 20 && fired[p] == f0; t++) step();
        memreq_val[p] = 1'b0;
        check("issue_accept", fired[p] - f0, 1);
    endtask

    task automatic wait_obs(input int p, input int n);
        for (int t = 0; t < 60 && obs_msg[p].size() < n; t++) step();
        check($sformatf("resp_count%0d", p), obs_msg[p].size(), n);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NP; i++) begin
            obs_msg[i].delete();
            obs_lat[i].delete();
        end
    endtask

    initial begin
        int f0;
        int f1;
        int f2;
        logic [7:0] v;
        reset       = 1'b0;
        memreq_val  = '0;
        memreq_msg  = '0;
        memresp_rdy = '1;
        for (int i = 0; i < NP; i++) fired[i] = 0;
        for (int j = 0; j < MEM; j++) begin
            v          = 8'($urandom);
            dut.m[j]  <= v;
            ref_mem[j] = v;
        end

        // Reset state, then release.
        repeat (3) step();
        reset = 1'b1;
        step();
        live = 1;
        check("rdy_after_release", memreq_rdy, {NP{1'b1}});

        // Word write then read on port 0.
        clear_obs();
        issue(0, mk_req(1, 16'h0000, 0, 32'h0a0b0c0d));
        issue(0, mk_req(0, 16'h0000, 0, 32'h0));
        wait_obs(0, 2);
        check("wr_resp", obs_msg[0][0], mk_resp(1, 0, 32'h0));
        check("wr_lat", obs_lat[0][0], LAT);
        check("rd_word", obs_msg[0][1], mk_resp(0, 0, 32'h0a0b0c0d));
        check("rd_lat", obs_lat[0][1], LAT);

        // Byte overwrite, byte reads and halfword read.
        clear_obs();
        issue(0, mk_req(1, 16'h0008, 0, 32'h0a0b0c0d));
        issue(0, mk_req(1, 16'h0008, 1, 32'h000000ef));
        for (int k = 0; k < 4; k++) issue(0, mk_req(0, 8 + k, 1, 32'hffffffff));
        issue(0, mk_req(0, 16'h000a, 2, 32'h0));
        wait_obs(0, 7);
        check("byte8", obs_msg[0][2], mk_resp(0, 1, 32'h000000ef));
        check("byte9", obs_msg[0][3], mk_resp(0, 1, 32'h0000000c));
        check("byteA", obs_msg[0][4], mk_resp(0, 1, 32'h0000000b));
        check("byteB", obs_msg[0][5], mk_resp(0, 1, 32'h0000000a));
        check("hwordA", obs_msg[0][6], mk_resp(0, 2, 32'h00000a0b));

        // Same-cycle writes on ports 0 and 1 with a read on port 2.
        clear_obs();
        issue(2, mk_req(1, 16'h0010, 0, 32'h5a5a5a5a));
        f0 = fired[0];
        f1 = fired[1];
        f2 = fired[2];
        memreq_val = '1;
        memreq_msg[0*REQW +: REQW] = mk_req(1, 16'h0010, 0, 32'h11111111);
        memreq_msg[1*REQW +: REQW] = mk_req(1, 16'h0010, 0, 32'h22222222);
        memreq_msg[2*REQW +: REQW] = mk_req(0, 16'h0010, 0, 32'h0);
        step();
        memreq_val = '0;
        check("same_cycle_acc", (fired[0] - f0) + (fired[1] - f1) + (fired[2] - f2), 3);
        issue(2, mk_req(0, 16'h0010, 0, 32'h0));
        wait_obs(2, 3);
        check("read_pre_cycle", obs_msg[2][1], mk_resp(0, 0, 32'h5a5a5a5a));
        check("high_port_wins", obs_msg[2][2], mk_resp(0, 0, 32'h22222222));

        // Wrap-around at the top of memory.
        clear_obs();
        issue(0, mk_req(1, 16'h03fe, 0, 32'haabbccdd));
        issue(0, mk_req(0, 16'h03fe, 1, 32'h0));
        issue(0, mk_req(0, 16'h03ff, 1, 32'h0));
        issue(0, mk_req(0, 16'h0000, 1, 32'h0));
        issue(0, mk_req(0, 16'h0001, 1, 32'h0));
        issue(0, mk_req(0, 16'h03fe, 0, 32'h0));
        wait_obs(0, 6);
        check("wrap_3fe", obs_msg[0][1], mk_resp(0, 1, 32'hdd));
        check("wrap_3ff", obs_msg[0][2], mk_resp(0, 1, 32'hcc));
        check("wrap_000", obs_msg[0][3], mk_resp(0, 1, 32'hbb));
        check("wrap_001", obs_msg[0][4], mk_resp(0, 1, 32'haa));
        check("wrap_word", obs_msg[0][5], mk_resp(0, 0, 32'haabbccdd));

        // Credit exhaustion on port 1 while port 0 streams.
        clear_obs();
        for (int k = 0; k < 4; k++) issue(1, mk_req(1, 32 + 4*k, 0, 32'h100 + k));
        wait_obs(1, 4);
        clear_obs();
        memresp_rdy[1] = 1'b0;
        f0 = fired[0];
        f1 = fired[1];
        for (int k = 0; k < 6; k++) begin
            memreq_val[1:0] = 2'b11;
            memreq_msg[0*REQW +: REQW] = mk_req(0, 16'h0080 + 4*k, 0, 32'h0);
            memreq_msg[1*REQW +: REQW] = mk_req(0, 32 + 4*k, 0, 32'h0);
            step();
        end
        memreq_val = '0;
        check("bp_accepted", fired[1] - f1, 4);
        check("bp_rdy_low", memreq_rdy[1], 1'b0);
        check("p0_accepted", fired[0] - f0, 6);
        check("p0_streamed", obs_msg[0].size(), 4);
        repeat (3) step();
        check("bp_still_low", memreq_rdy[1], 1'b0);
        memresp_rdy[1] = 1'b1;
        wait_obs(1, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("bp_order%0d", k), obs_msg[1][k], mk_resp(0, 0, 32'h100 + k));

        // Reset with three responses outstanding.
        memresp_rdy = '0;
        issue(0, mk_req(1, 16'h0040, 0, 32'hdeadbeef));
        issue(0, mk_req(0, 16'h0040, 0, 32'h0));
        issue(0, mk_req(0, 16'h0044, 0, 32'h0));
        reset = 1'b0;
        #1;
        check("rst_val_low", memresp_val, '0);
        check("rst_rdy_low", memreq_rdy, '0);
        live = 0;
        for (int i = 0; i < NP; i++) pend[i].delete();
        repeat (3) step();
        reset = 1'b1;
        step();
        live = 1;
        memresp_rdy = '1;
        check("rdy_after_rerelease", memreq_rdy, {NP{1'b1}});
        repeat (5) step();
        clear_obs();
        issue(0, mk_req(0, 16'h0040, 0, 32'h0));
        wait_obs(0, 1);
        check("mem_retained", obs_msg[0][0], mk_resp(0, 0, 32'hdeadbeef));

        // Random traffic on all ports with random sink stalls.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                memreq_val[i]  = ($urandom_range(0, 3) != 0);
                memresp_rdy[i] = ($urandom_range(0, 3) != 0);
                memreq_msg[i*REQW +: REQW] = mk_req(
                    1'($urandom_range(0, 1)),
                    int'((($urandom_range(0, 7) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 63))
                         + MEM * $urandom_range(0, 3)),
                    int'($urandom_range(0, NB-1)),
                    32'($urandom));
            end
            step();
        end
        memreq_val  = '0;
        memresp_rdy = '1;
        repeat (20) step();
        for (int i = 0; i < NP; i++) check($sformatf("drained%0d", i), pend[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
